// File: rtl/mops_pulse_gen.sv
// Synthetic 3-PMT MoPS trace source: staircase rise, exponential decay, flat baseline.
// One sample per 40 MHz tick (registered ENABLE40==0), no backpressure; START/STOP/DONE/BUSY act on any edge.
module mops_pulse_gen #(
    parameter int ADC_WIDTH   = 12,
    parameter int NSTEP_BITS  = 4,
    parameter int GAP_BITS    = 16,
    parameter int NPULSE_BITS = 8
) (
    input  logic                   i_clk120,
    input  logic                   i_reset,
    input  logic [1:0]             i_enable40,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [2:0]             i_ch_enable,
    input  logic [ADC_WIDTH-1:0]   i_baseline,
    input  logic [ADC_WIDTH-1:0]   i_amp0,
    input  logic [ADC_WIDTH-1:0]   i_amp1,
    input  logic [ADC_WIDTH-1:0]   i_amp2,
    input  logic [NSTEP_BITS-1:0]  i_nsteps,
    input  logic [2:0]             i_decay_shift,
    input  logic [GAP_BITS-1:0]    i_gap,
    input  logic [NPULSE_BITS-1:0] i_npulses,
    output logic [ADC_WIDTH-1:0]   o_adc0,
    output logic [ADC_WIDTH-1:0]   o_adc1,
    output logic [ADC_WIDTH-1:0]   o_adc2,
    output logic                   o_pulse_mark,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [NPULSE_BITS-1:0] o_pulse_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RISE,
        S_DECAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_en40;

    logic [ADC_WIDTH-1:0]   r_base;
    logic [ADC_WIDTH-1:0]   r_amp [3];
    logic [2:0]             r_ch_en;
    logic [NSTEP_BITS-1:0]  r_nsteps;
    logic [2:0]             r_shift;
    logic [GAP_BITS-1:0]    r_gap;
    logic [NPULSE_BITS-1:0] r_npulses;

    logic [ADC_WIDTH-1:0]   r_adc [3];
    logic                   r_mark;
    logic                   r_busy;
    logic                   r_done;
    logic [NPULSE_BITS-1:0] r_count;
    logic [NSTEP_BITS-1:0]  r_kcnt;
    logic [GAP_BITS-1:0]    r_gcnt;

    logic [ADC_WIDTH-1:0]   w_adc_nxt [3];
    logic                   w_mark_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic [NPULSE_BITS-1:0] w_count_nxt;
    logic [NSTEP_BITS-1:0]  w_kcnt_nxt;
    logic [GAP_BITS-1:0]    w_gcnt_nxt;

    logic                   w_tick;
    logic                   w_accept;
    logic                   w_all_base;
    logic [NSTEP_BITS-1:0]  w_kcnt_inc;
    logic [ADC_WIDTH:0]     w_sum   [3];
    logic [ADC_WIDTH-1:0]   w_exc   [3];
    logic [ADC_WIDTH-1:0]   w_dstep [3];
    logic [ADC_WIDTH-1:0]   w_rise  [3];
    logic [ADC_WIDTH-1:0]   w_dec   [3];

    assign w_tick     = (r_en40 == 2'd0);
    assign w_accept   = (r_state == S_IDLE) && i_start && !i_stop;
    assign w_kcnt_inc = r_kcnt + NSTEP_BITS'(1);

    // Rise adds one extra bit so an overflow clips to full scale instead of wrapping.
    always_comb begin
        w_all_base = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_sum[i]   = {1'b0, r_adc[i]} + {1'b0, r_amp[i]};
            w_exc[i]   = r_adc[i] - r_base;
            w_dstep[i] = w_exc[i] >> r_shift;
            w_rise[i]  = !r_ch_en[i] ? r_base :
                         (w_sum[i][ADC_WIDTH] ? '1 : w_sum[i][ADC_WIDTH-1:0]);
            w_dec[i]   = (!r_ch_en[i] || (w_dstep[i] == '0)) ? r_base : (r_adc[i] - w_dstep[i]);
            w_all_base = w_all_base & (w_dec[i] == r_base);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mark_nxt  = r_mark;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_count_nxt = r_count;
        w_kcnt_nxt  = r_kcnt;
        w_gcnt_nxt  = r_gcnt;
        for (int i = 0; i < 3; i++) begin
            w_adc_nxt[i] = r_adc[i];
        end

        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_mark_nxt = 1'b0;
                    for (int i = 0; i < 3; i++) w_adc_nxt[i] = i_baseline;
                end
                if (w_accept) begin
                    w_state_nxt = S_ARMED;
                    w_busy_nxt  = 1'b1;
                    w_count_nxt = '0;
                end
            end
            S_ARMED: begin
                if (w_tick) begin
                    w_state_nxt = S_RISE;
                    w_mark_nxt  = 1'b0;
                    w_kcnt_nxt  = '0;
                    for (int i = 0; i < 3; i++) w_adc_nxt[i] = r_base;
                end
            end
            S_RISE: begin
                if (w_tick) begin
                    w_kcnt_nxt = w_kcnt_inc;
                    w_mark_nxt = (r_kcnt == '0);
                    for (int i = 0; i < 3; i++) w_adc_nxt[i] = w_rise[i];
                    if ((r_kcnt == '0) && (r_count != '1)) begin
                        w_count_nxt = r_count + NPULSE_BITS'(1);
                    end
                    if (w_kcnt_inc == r_nsteps) begin
                        w_state_nxt = S_DECAY;
                    end
                end
            end
            S_DECAY: begin
                if (w_tick) begin
                    w_mark_nxt = 1'b0;
                    for (int i = 0; i < 3; i++) w_adc_nxt[i] = w_dec[i];
                    if (w_all_base) begin
                        if ((r_npulses == '0) || (r_count < r_npulses)) begin
                            w_state_nxt = S_GAP;
                            w_gcnt_nxt  = '0;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_mark_nxt = 1'b0;
                    if (r_gcnt == r_gap) begin
                        w_state_nxt = S_RISE;
                        w_kcnt_nxt  = '0;
                    end else begin
                        w_gcnt_nxt = r_gcnt + GAP_BITS'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides whatever the train would have done on this edge.
        if ((r_state != S_IDLE) && i_stop) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            if (w_tick) begin
                w_mark_nxt = 1'b0;
                for (int i = 0; i < 3; i++) w_adc_nxt[i] = i_baseline;
            end
        end
    end

    always_ff @(posedge i_clk120) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_en40    <= 2'd0;
            r_base    <= '0;
            r_ch_en   <= '0;
            r_nsteps  <= '0;
            r_shift   <= '0;
            r_gap     <= '0;
            r_npulses <= '0;
            r_mark    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_kcnt    <= '0;
            r_gcnt    <= '0;
            for (int i = 0; i < 3; i++) begin
                r_amp[i] <= '0;
                r_adc[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_en40  <= i_enable40;
            r_mark  <= w_mark_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            r_kcnt  <= w_kcnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            for (int i = 0; i < 3; i++) begin
                r_adc[i] <= w_adc_nxt[i];
            end
            if (w_accept) begin
                r_base    <= i_baseline;
                r_amp[0]  <= i_amp0;
                r_amp[1]  <= i_amp1;
                r_amp[2]  <= i_amp2;
                r_ch_en   <= i_ch_enable;
                r_nsteps  <= (i_nsteps == '0) ? NSTEP_BITS'(1) : i_nsteps;
                r_shift   <= i_decay_shift;
                r_gap     <= i_gap;
                r_npulses <= i_npulses;
            end
        end
    end

    assign o_adc0        = r_adc[0];
    assign o_adc1        = r_adc[1];
    assign o_adc2        = r_adc[2];
    assign o_pulse_mark  = r_mark;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pulse_count = r_count;

endmodule
